// File: rtl/framebuffer_arbiter.sv
// Arbitrates one single-port framebuffer RAM between display reads, drawing-engine writes
// and a background clear-screen engine (priority: display > write > clear).
module framebuffer_arbiter #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              disp_req,
  input  logic [10:0]       disp_x,
  input  logic [9:0]        disp_y,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [10:0]       wr_x,
  input  logic [9:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_colour,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              oob_flag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [10:0]       H_LIMIT   = 11'(H_ACTIVE);
  localparam logic [9:0]        V_LIMIT   = 10'(V_ACTIVE);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0]   colour_q, colour_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                we_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                done_d;
  logic                oob_d;
  logic                wr_accept;
  logic                wr_in_range;
  logic [2:0]          rd_tag;

  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [10:0] x, input logic [9:0] y);
    return ADDR_W'(y) * ADDR_W'(H_ACTIVE) + ADDR_W'(x);
  endfunction

  // Gated by reset so the drawing engine never sees a ready while the arbiter is held in reset
  assign wr_ready    = Reset_n && !disp_req && (state_q == IDLE);
  assign wr_accept   = wr_valid && wr_ready;
  assign wr_in_range = (wr_x < H_LIMIT) && (wr_y < V_LIMIT);
  assign clear_busy  = (state_q == CLEAR);
  assign disp_valid  = rd_tag[2];

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    colour_d   = colour_q;
    addr_d     = mem_addr;
    we_d       = 1'b0;
    wdata_d    = mem_wdata;
    done_d     = 1'b0;
    oob_d      = oob_flag;

    if (disp_req) begin
      addr_d = pixel_addr(disp_x, disp_y);
    end else if (wr_accept) begin
      if (wr_in_range) begin
        we_d    = 1'b1;
        addr_d  = pixel_addr(wr_x, wr_y);
        wdata_d = wr_data;
      end else begin
        oob_d = 1'b1;
      end
    end else if (state_q == CLEAR) begin
      we_d    = 1'b1;
      addr_d  = clr_addr_q;
      wdata_d = colour_q;
      if (clr_addr_q == LAST_ADDR) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
      end
    end

    // A write accepted alongside clear_start still lands this cycle; the fill begins next cycle
    if (state_q == IDLE && clear_start) begin
      state_d    = CLEAR;
      colour_d   = clear_colour;
      clr_addr_d = '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      clr_addr_q <= '0;
      colour_q   <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      clear_done <= 1'b0;
      oob_flag   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      colour_q   <= colour_d;
      mem_addr   <= addr_d;
      mem_we     <= we_d;
      mem_wdata  <= wdata_d;
      clear_done <= done_d;
      oob_flag   <= oob_d;
    end
  end

  // rd_tag[1] lines up with the RAM returning data for the address issued a cycle earlier
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_tag    <= '0;
      disp_data <= '0;
    end else begin
      rd_tag <= {rd_tag[1:0], disp_req};
      if (rd_tag[1]) begin
        disp_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Randomised bench for framebuffer_arbiter on a reduced 80x60 frame, checked every cycle
// against a pixel-level model with its own golden frame image.
module tb_framebuffer_arbiter;

  localparam int H   = 80;
  localparam int V   = 60;
  localparam int AW  = 13;
  localparam int DW  = 8;
  localparam int PIX = H * V;

  logic          Clock;
  logic          Reset_n = 1'b1;
  logic          disp_req = 1'b0;
  logic [10:0]   disp_x = '0;
  logic [9:0]    disp_y = '0;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [10:0]   wr_x = '0;
  logic [9:0]    wr_y = '0;
  logic [DW-1:0] wr_data = '0;
  logic          clear_start = 1'b0;
  logic [DW-1:0] clear_colour = '0;
  logic          clear_busy;
  logic          clear_done;
  logic          oob_flag;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  // Model state: golden image plus what the arbiter must present after each edge
  bit [7:0] golden [0:PIX-1];
  bit       m_clearing;
  int       m_pos;
  bit [7:0] m_col;
  bit       e_we, e_rd, e_done, e_oob;
  int       e_addr;
  bit [7:0] e_wdata;
  bit       pend;
  int       pend_addr;
  bit [7:0] pend_data;
  bit       pv [3];
  bit [7:0] pd [3];

  framebuffer_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .clear_start(clear_start), .clear_colour(clear_colour),
    .clear_busy(clear_busy), .clear_done(clear_done), .oob_flag(oob_flag),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic bit [7:0] preload(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_stimulus(input bit dreq, input int dx, input int dy, input bit wv,
                                input int wx, input int wy, input int wd);
    disp_req = dreq;
    disp_x   = 11'(dx);
    disp_y   = 10'(dy);
    wr_valid = wv;
    wr_x     = 11'(wx);
    wr_y     = 10'(wy);
    wr_data  = 8'(wd);
  endtask

  // Synchronous single-port RAM: data appears one cycle after its address
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = preload(i);
    forever begin
      @(posedge Clock);
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  // Reference model: per edge, decide which single access the rules grant
  initial begin
    bit start_ok;
    for (int i = 0; i < PIX; i++) golden[i] = preload(i);
    forever begin
      @(posedge Clock or negedge Reset_n);
      if (!Reset_n) begin
        m_clearing = 0; m_pos = 0; m_col = 0;
        e_we = 0; e_rd = 0; e_done = 0; e_oob = 0; pend = 0;
        for (int k = 0; k < 3; k++) begin pv[k] = 0; pd[k] = 0; end
      end else begin
        if (pend) golden[pend_addr] = pend_data;
        pend = 0;
        pv[2] = pv[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = 0;
        e_we = 0; e_rd = 0; e_done = 0;
        start_ok = !m_clearing && clear_start;
        if (disp_req) begin
          e_rd   = 1;
          e_addr = int'(disp_y) * H + int'(disp_x);
          pv[0]  = 1;
          pd[0]  = golden[e_addr];
        end else if (wr_valid && !m_clearing) begin
          if (int'(wr_x) < H && int'(wr_y) < V) begin
            e_we = 1; e_addr = int'(wr_y) * H + int'(wr_x); e_wdata = wr_data;
            pend = 1; pend_addr = e_addr; pend_data = wr_data;
          end else begin
            e_oob = 1;
          end
        end else if (m_clearing) begin
          e_we = 1; e_addr = m_pos; e_wdata = m_col;
          pend = 1; pend_addr = m_pos; pend_data = m_col;
          m_pos++;
          if (m_pos == PIX) begin
            m_clearing = 0;
            e_done = 1;
          end
        end
        if (start_ok) begin
          m_clearing = 1; m_pos = 0; m_col = clear_colour;
        end
      end
    end
  end

  always @(negedge Clock) begin
    if (!Reset_n) begin
      check_output("rst_mem_we", mem_we, 0);
      check_output("rst_mem_addr", mem_addr, 0);
      check_output("rst_disp_valid", disp_valid, 0);
      check_output("rst_clear_busy", clear_busy, 0);
      check_output("rst_clear_done", clear_done, 0);
      check_output("rst_oob", oob_flag, 0);
      check_output("rst_wr_ready", wr_ready, 0);
    end else begin
      check_output("wr_ready", wr_ready, 32'(!disp_req && !m_clearing));
      check_output("mem_we", mem_we, 32'(e_we));
      if (e_we || e_rd) check_output("mem_addr", mem_addr, 32'(e_addr));
      if (e_we) check_output("mem_wdata", mem_wdata, 32'(e_wdata));
      check_output("disp_valid", disp_valid, 32'(pv[2]));
      if (pv[2]) check_output("disp_data", disp_data, 32'(pd[2]));
      check_output("clear_busy", clear_busy, 32'(m_clearing));
      check_output("clear_done", clear_done, 32'(e_done));
      check_output("oob_flag", oob_flag, 32'(e_oob));
    end
  end

  initial begin
    int wcnt, dn, ready_bad, dup, found;
    int seen [PIX];
    bit w_hold, acc;

    #2 Reset_n = 1'b0;
    repeat (3) tick();
    check_output("lit_reset_addr", mem_addr, 0);
    check_output("lit_reset_wr_ready", wr_ready, 0);
    Reset_n = 1'b1;
    tick();

    // Back-to-back display reads at both frame corners
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    check_output("lit_rd0_addr", mem_addr, 0);
    check_output("lit_rd0_we", mem_we, 0);
    apply_stimulus(1, 79, 59, 0, 0, 0, 0);
    tick();
    check_output("lit_rd1_addr", mem_addr, 4799);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    check_output("lit_rd0_valid", disp_valid, 1);
    check_output("lit_rd0_data", disp_data, 8'd5);
    tick();
    check_output("lit_rd1_valid", disp_valid, 1);
    check_output("lit_rd1_data", disp_data, 8'd160);
    tick();
    check_output("lit_rd_idle_valid", disp_valid, 0);

    // Simple write (10,2) -> 2*80+10
    apply_stimulus(0, 0, 0, 1, 10, 2, 8'hAB);
    #1 check_output("lit_wr_ready", wr_ready, 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("lit_wr_we", mem_we, 1);
    check_output("lit_wr_addr", mem_addr, 170);
    check_output("lit_wr_data", mem_wdata, 8'hAB);

    // Write held behind five display cycles
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, $urandom_range(H-1), $urandom_range(V-1), 1, 3, 4, 8'h55);
      #1 check_output("lit_stall_ready", wr_ready, 0);
      tick();
      check_output("lit_stall_we", mem_we, 0);
    end
    apply_stimulus(0, 0, 0, 1, 3, 4, 8'h55);
    #1 check_output("lit_unstall_ready", wr_ready, 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("lit_unstall_we", mem_we, 1);
    check_output("lit_unstall_addr", mem_addr, 323);
    tick();
    check_output("lit_single_write", mem_we, 0);

    // Out-of-range writes are swallowed
    apply_stimulus(0, 0, 0, 1, 80, 0, 8'h11);
    tick();
    check_output("lit_oob1_we", mem_we, 0);
    check_output("lit_oob1_flag", oob_flag, 1);
    apply_stimulus(0, 0, 0, 1, 0, 60, 8'h22);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("lit_oob2_we", mem_we, 0);
    tick();
    check_output("lit_oob_sticky", oob_flag, 1);

    // Full clear, started alongside a display read, with a write held throughout
    for (int i = 0; i < PIX; i++) seen[i] = 0;
    wcnt = 0; dn = 0; ready_bad = 0;
    apply_stimulus(1, 1, 1, 1, 5, 5, 8'h77);
    clear_start = 1'b1; clear_colour = 8'h1F;
    tick();
    clear_start = 1'b0;
    for (int c = 0; c < 4 * PIX; c++) begin
      apply_stimulus($urandom_range(1), $urandom_range(H-1), $urandom_range(V-1), 1, 5, 5, 8'h77);
      #1 if (clear_busy && wr_ready) ready_bad++;
      tick();
      if (mem_we) begin
        wcnt++;
        if (int'(mem_addr) < PIX && mem_wdata == 8'h1F) seen[mem_addr]++;
      end
      if (clear_done) begin
        dn++;
        break;
      end
    end
    dup = 0;
    for (int i = 0; i < PIX; i++) if (seen[i] != 1) dup++;
    check_output("clear_write_count", wcnt, PIX);
    check_output("clear_addr_coverage", dup, 0);
    check_output("clear_done_pulses", dn, 1);
    check_output("clear_ready_low", ready_bad, 0);
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      apply_stimulus(0, 0, 0, 1, 5, 5, 8'h77);
      tick();
      if (mem_we && mem_addr == 13'd405) found = 1;
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("held_write_after_clear", found, 1);
    tick();

    // Reset in the middle of a clear, then a fresh clear restarts at 0
    clear_start = 1'b1; clear_colour = 8'h2C;
    tick();
    clear_start = 1'b0;
    found = 0;
    for (int c = 0; c < 4 * PIX && found == 0; c++) begin
      apply_stimulus($urandom_range(1), $urandom_range(H-1), $urandom_range(V-1), 0, 0, 0, 0);
      tick();
      if (mem_we && mem_addr == 13'd1000) found = 1;
    end
    check_output("reached_addr_1000", found, 1);
    Reset_n = 1'b0;
    #1;
    check_output("async_rst_we", mem_we, 0);
    check_output("async_rst_addr", mem_addr, 0);
    check_output("async_rst_busy", clear_busy, 0);
    check_output("async_rst_oob", oob_flag, 0);
    check_output("async_rst_done", clear_done, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    Reset_n = 1'b1;
    tick();
    check_output("post_rst_busy", clear_busy, 0);
    clear_start = 1'b1; clear_colour = 8'h3D;
    tick();
    clear_start = 1'b0;
    found = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      apply_stimulus($urandom_range(1), $urandom_range(H-1), $urandom_range(V-1), 0, 0, 0, 0);
      tick();
      if (mem_we) begin
        found = 1;
        check_output("restart_addr", mem_addr, 0);
        check_output("restart_colour", mem_wdata, 8'h3D);
      end
    end
    check_output("restart_seen", found, 1);
    found = 0;
    for (int c = 0; c < 4 * PIX && found == 0; c++) begin
      apply_stimulus($urandom_range(1), $urandom_range(H-1), $urandom_range(V-1), 0, 0, 0, 0);
      tick();
      if (clear_done) found = 1;
    end
    check_output("second_clear_done", found, 1);

    // Random mixed traffic with held writes, occasional out-of-range ones and rare clears
    w_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!w_hold && $urandom_range(2) == 0) begin
        w_hold = 1;
        if ($urandom_range(9) == 0) begin
          wr_x = 11'(H + $urandom_range(200));
          wr_y = 10'($urandom_range(V-1));
        end else begin
          wr_x = 11'($urandom_range(H-1));
          wr_y = 10'($urandom_range(V-1));
        end
        wr_data = 8'($urandom_range(255));
      end
      wr_valid     = w_hold;
      disp_req     = $urandom_range(1);
      disp_x       = 11'($urandom_range(H-1));
      disp_y       = 10'($urandom_range(V-1));
      clear_start  = ($urandom_range(1499) == 0);
      clear_colour = 8'($urandom_range(255));
      #1 acc = wr_valid && wr_ready;
      tick();
      if (acc) w_hold = 0;
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    clear_start = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
